// File: rtl/lau_pkg.sv
// Shared arithmetic-library package: speed selector and small elaboration helpers.
package lau_pkg;

    typedef enum logic {
        SMALL = 1'b0,
        FAST  = 1'b1
    } speed_e;

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_add_addc.sv
// Library carry-in/carry-out adder: {co, s} = a + b + ci, combinational.
module seq_add_addc
    import lau_pkg::*;
#(
    parameter int unsigned width = 16,
    parameter speed_e      speed = FAST
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             ci_i,
    output logic [width-1:0] sum_c_o,
    output logic             cout_c_o
);

    localparam int unsigned W1 = width + 1;

    generate
        if (speed == FAST) begin : g_fast
            // Leave carry structure to the synthesis tool's adder mapping.
            assign {cout_c_o, sum_c_o} = W1'(a_i) + W1'(b_i) + W1'(ci_i);
        end else begin : g_ripple
            logic [width-1:0] sum_r;
            logic             cout_r;

            always_comb begin
                logic c;
                c     = ci_i;
                sum_r = '0;
                for (int i = 0; i < int'(width); i++) begin
                    sum_r[i] = a_i[i] ^ b_i[i] ^ c;
                    c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
                end
                cout_r = c;
            end

            assign sum_c_o  = sum_r;
            assign cout_c_o = cout_r;
        end
    endgenerate

endmodule

// File: rtl/seq_add.sv
// Chunk-serial adder: S = A + B + CI, `chunk` bits per cycle with a registered carry,
// between a valid/ready producer and consumer.
module seq_add
    import lau_pkg::*;
#(
    parameter int unsigned width = 64,
    parameter int unsigned chunk = 16,
    parameter speed_e      speed = FAST
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             ci_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] s_o,
    output logic             co_o
);

    localparam int unsigned N  = width / chunk;
    localparam int unsigned CW = cnt_bits(N);
    localparam int unsigned IW = cnt_bits(width);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((chunk < 1) || ((width % chunk) != 0)) begin : g_bad_cfg
            $error("seq_add: width must be a nonzero multiple of chunk");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [width-1:0] a_q, a_d;
    logic [width-1:0] b_q, b_d;
    logic [width-1:0] s_q, s_d;
    logic             co_q, co_d;

    logic [IW-1:0]    base_c;
    logic [chunk-1:0] a_chunk_c;
    logic [chunk-1:0] b_chunk_c;
    logic [chunk-1:0] sum_c;
    logic             cout_c;
    logic             accept_c;

    // Reset masks ready so nothing is accepted on the edge that clears the block.
    assign in_ready_o = ~rst_i & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
    assign accept_c   = in_valid_i & in_ready_o;

    assign base_c    = IW'(cnt_q * chunk);
    assign a_chunk_c = a_q[base_c +: chunk];
    assign b_chunk_c = b_q[base_c +: chunk];

    seq_add_addc #(
        .width (chunk),
        .speed (speed)
    ) u_addc (
        .a_i      (a_chunk_c),
        .b_i      (b_chunk_c),
        .ci_i     (carry_q),
        .sum_c_o  (sum_c),
        .cout_c_o (cout_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[base_c +: chunk] = sum_c;
                carry_d              = cout_c;
                if (cnt_q == LAST) begin
                    co_d    = cout_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = accept_c ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept is only possible from IDLE or a completing DONE, never during RUN.
        if (accept_c) begin
            a_d     = a_i;
            b_d     = b_i;
            carry_d = ci_i;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign out_valid_o = (state_q == DONE);
    assign s_o         = s_q;
    assign co_o        = co_q;

endmodule

// File: tb/tb_seq_add.sv
// Directed and model-checked bench for seq_add across four width/chunk configurations.
module tb_seq_add;
    import lau_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a_w, b_w;
    logic        ci_w;
    logic [3:0]  in_valid, out_ready, in_ready, out_valid, co;
    logic [15:0] s0;
    logic [63:0] s1, s2;
    logic [11:0] s3;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    seq_add #(.width(16), .chunk(4), .speed(SMALL)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .a_i(a_w[15:0]), .b_i(b_w[15:0]), .ci_i(ci_w), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]), .s_o(s0), .co_o(co[0]));

    seq_add #(.width(64), .chunk(16), .speed(FAST)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .a_i(a_w), .b_i(b_w), .ci_i(ci_w), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]), .s_o(s1), .co_o(co[1]));

    seq_add #(.width(64), .chunk(64), .speed(SMALL)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .a_i(a_w), .b_i(b_w), .ci_i(ci_w), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready[2]), .s_o(s2), .co_o(co[2]));

    seq_add #(.width(12), .chunk(1), .speed(FAST)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[3]), .in_ready_o(in_ready[3]),
        .a_i(a_w[11:0]), .b_i(b_w[11:0]), .ci_i(ci_w), .out_valid_o(out_valid[3]),
        .out_ready_i(out_ready[3]), .s_o(s3), .co_o(co[3]));

    task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] result_of(input int sel);
        case (sel)
            0:       return {co[0], 64'(s0)};
            1:       return {co[1], s1};
            2:       return {co[2], s2};
            default: return {co[3], 64'(s3)};
        endcase
    endfunction

    function automatic int n_of(input int sel);
        case (sel)
            0:       return 4;
            1:       return 4;
            2:       return 1;
            default: return 12;
        endcase
    endfunction

    function automatic int width_of(input int sel);
        case (sel)
            0:       return 16;
            3:       return 12;
            default: return 64;
        endcase
    endfunction

    // One complete operation with out_ready held high; lat counts edges from accept to valid.
    task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, output logic [64:0] res, output int lat,
                          output logic busy_ok);
        int waitc;
        @(negedge clk);
        a_w = a;
        b_w = b;
        ci_w = ci;
        in_valid[2'(sel)]  = 1'b1;
        out_ready[2'(sel)] = 1'b1;
        #1;
        waitc = 0;
        while (!in_ready[2'(sel)] && waitc < 50) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[2'(sel)] = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid[2'(sel)] && lat < 100) begin
            if (in_ready[2'(sel)]) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        res = result_of(sel);
    endtask

    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic        pc [3];
    logic [64:0] pexp [3];

    initial begin
        logic [64:0] res, full, exp;
        logic [63:0] m, ra, rb;
        logic        busy_ok, rc;
        int          lat, idx_in, idx_out, cyc, w;
        int          acc_t [3];

        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        a_w = '0;
        b_w = '0;
        ci_w = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_in_ready_forced", 65'(in_ready), 65'h0);
        @(negedge clk);
        check_eq("rst_out_valid", 65'(out_valid), 65'h0);
        check_eq("rst_sum0", result_of(0), 65'h0);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready", 65'(in_ready), 65'hF);

        // Full carry ripple and latency
        run_op(0, 64'hFFFF, 64'h0001, 1'b0, res, lat, busy_ok);
        check_eq("ffff_plus_1", res, {1'b1, 64'h0000});
        check_eq("latency_n4", 65'(lat), 65'd4);

        run_op(0, 64'h1234, 64'h4321, 1'b1, res, lat, busy_ok);
        check_eq("1234_4321_ci", res, {1'b0, 64'h5556});
        check_eq("busy_in_run", 65'(busy_ok), 65'd1);

        // Backpressure: hold result while a second pair waits
        @(negedge clk);
        a_w = 64'h00FF;
        b_w = 64'h0001;
        ci_w = 1'b0;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        a_w = 64'h0F0F;
        b_w = 64'h1010;
        ci_w = 1'b1;
        in_valid[0] = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 65'(out_valid[0]), 65'd1);
            check_eq("bp_hold", result_of(0), {1'b0, 64'h0100});
            check_eq("bp_not_ready", 65'(in_ready[0]), 65'd0);
            @(negedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        #1;
        check_eq("bp_release_ready", 65'(in_ready[0]), 65'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check_eq("bp_second_running", 65'(out_valid[0]), 65'd0);
        lat = 0;
        while (!out_valid[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq("bp_second_lat", 65'(lat), 65'd4);
        check_eq("bp_second_sum", result_of(0), {1'b0, 64'h1F20});

        // Back-to-back with continuous valid
        pa[0] = 16'h8000; pb[0] = 16'h8000; pc[0] = 1'b0; pexp[0] = {1'b1, 64'h0000};
        pa[1] = 16'h1111; pb[1] = 16'h2222; pc[1] = 1'b1; pexp[1] = {1'b0, 64'h3334};
        pa[2] = 16'hFFFF; pb[2] = 16'hFFFF; pc[2] = 1'b1; pexp[2] = {1'b1, 64'hFFFF};
        idx_in = 0;
        idx_out = 0;
        acc_t = '{0, 0, 0};
        for (cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                if (idx_out < 3) check_eq("b2b_sum", result_of(0), pexp[idx_out]);
                idx_out++;
            end
            if (idx_in < 3) begin
                a_w = 64'(pa[idx_in]);
                b_w = 64'(pb[idx_in]);
                ci_w = pc[idx_in];
                in_valid[0] = 1'b1;
            end else begin
                in_valid[0] = 1'b0;
            end
            #1;
            if (in_valid[0] && in_ready[0]) begin
                acc_t[idx_in] = cyc;
                idx_in++;
            end
        end
        check_eq("b2b_count", 65'(idx_out), 65'd3);
        check_eq("b2b_gap01", 65'(acc_t[1] - acc_t[0]), 65'd5);
        check_eq("b2b_gap12", 65'(acc_t[2] - acc_t[1]), 65'd5);

        // Reset in the middle of an operation
        @(negedge clk);
        a_w = 64'hAAAA;
        b_w = 64'h5555;
        ci_w = 1'b0;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        check_eq("rmid_idle_ready", 65'(in_ready[0]), 65'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rmid_ready_forced", 65'(in_ready[0]), 65'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rmid_valid", 65'(out_valid[0]), 65'd0);
        check_eq("rmid_sum", result_of(0), 65'h0);
        check_eq("rmid_ready", 65'(in_ready[0]), 65'd1);
        run_op(0, 64'h0001, 64'h0001, 1'b0, res, lat, busy_ok);
        check_eq("after_rst_sum", res, {1'b0, 64'h0002});

        // Model-checked random operands on the wide configurations
        for (int sel = 1; sel < 4; sel++) begin
            w = width_of(sel);
            m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
            for (int k = 0; k < 1000; k++) begin
                ra = {$urandom(), $urandom()};
                rb = {$urandom(), $urandom()};
                rc = 1'($urandom());
                run_op(sel, ra, rb, rc, res, lat, busy_ok);
                full = {1'b0, ra & m} + {1'b0, rb & m} + 65'(rc);
                exp = {full[w], full[63:0] & m};
                check_eq("rand_sum", res, exp);
                check_eq("rand_lat", 65'(lat), 65'(n_of(sel)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
